// File: rtl/xor_share_arb_if.sv
// Request/grant/result bundle for xor_share_arb; master = requester side, slave = arbiter side.
interface xor_share_arb_if #(
    parameter int W = 8
);
    logic         req0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         req1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         gnt0;
    logic         gnt1;
    logic         ack0;
    logic         ack1;
    logic [W-1:0] y;
    logic         busy;
    logic [7:0]   ops;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, ack0, ack1, y, busy, ops
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, ack0, ack1, y, busy, ops
    );
endinterface

// File: rtl/xor_share_arb.sv
// Two-requester arbiter in front of one shared W-bit XOR unit (IDLE -> CALC -> DONE).
// Define XOR_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module xor_share_arb #(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    xor_share_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t       state;
    logic [W-1:0] la;
    logic [W-1:0] lb;
    logic [W-1:0] xr;
    logic         win1;

`ifdef XOR_ARB_RR_EN
    logic last;

    // On a tie, requester 1 wins only when requester 0 was served last.
    always_comb begin
        win1 = 1'b0;
        win1 = bus.req1 && (!bus.req0 || !last);
    end
`else
    always_comb begin
        win1 = 1'b0;
        win1 = bus.req1 && !bus.req0;
    end
`endif

    assign xr = la ^ lb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            la       <= '0;
            lb       <= '0;
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            bus.y    <= '0;
            bus.busy <= 1'b0;
            bus.ops  <= '0;
`ifdef XOR_ARB_RR_EN
            last     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        la       <= win1 ? bus.a1 : bus.a0;
                        lb       <= win1 ? bus.b1 : bus.b0;
                        bus.gnt0 <= !win1;
                        bus.gnt1 <= win1;
                        bus.busy <= 1'b1;
`ifdef XOR_ARB_RR_EN
                        last     <= win1;
`endif
                        state    <= CALC;
                    end
                end
                CALC: begin
                    bus.y    <= xr;
                    bus.ack0 <= bus.gnt0;
                    bus.ack1 <= bus.gnt1;
                    bus.ops  <= bus.ops + 8'd1;
                    state    <= DONE;
                end
                DONE: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    bus.gnt0 <= 1'b0;
                    bus.gnt1 <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xor_share_arb.sv
// Directed + randomized bench for xor_share_arb against a transaction-level reference model.
module tb_xor_share_arb;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   ntests;
    int   nfail;

    // reference model state
    int           exp_ops;
    int           exp_last;
    logic [W-1:0] exp_y;

    xor_share_arb_if #(.W(W)) bus ();

    xor_share_arb #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef XOR_ARB_RR_EN
            return (exp_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    task automatic model_reset();
        exp_ops  = 0;
        exp_last = 1;
        exp_y    = '0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        step();
        step();
        rst      = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        model_reset();
    endtask

    // One isolated operation; requests dropped and operands scrambled once granted.
    task automatic run_op(input bit r0, input bit r1,
                          input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                          input logic [W-1:0] xa1, input logic [W-1:0] xb1);
        int           w;
        logic [W-1:0] ey;
        bus.req0 = r0;
        bus.req1 = r1;
        bus.a0   = xa0;
        bus.b0   = xb0;
        bus.a1   = xa1;
        bus.b1   = xb1;
        w  = pick(r0, r1);
        ey = (w == 1) ? (xa1 ^ xb1) : (xa0 ^ xb0);
        step();
        chk("grant_gnt0", 32'(bus.gnt0), 32'(w == 0));
        chk("grant_gnt1", 32'(bus.gnt1), 32'(w == 1));
        chk("grant_busy", 32'(bus.busy), 32'd1);
        chk("grant_noack", 32'({bus.ack0, bus.ack1}), 32'd0);
        chk("grant_yheld", 32'(bus.y), 32'(exp_y));
        exp_last = w;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a0   = W'($urandom);
        bus.b0   = W'($urandom);
        bus.a1   = W'($urandom);
        bus.b1   = W'($urandom);
        step();
        exp_ops = (exp_ops + 1) % 256;
        exp_y   = ey;
        chk("done_ack0", 32'(bus.ack0), 32'(w == 0));
        chk("done_ack1", 32'(bus.ack1), 32'(w == 1));
        chk("done_y", 32'(bus.y), 32'(ey));
        chk("done_ops", 32'(bus.ops), 32'(exp_ops));
        chk("done_gnt", 32'({bus.gnt0, bus.gnt1}), (w == 0) ? 32'd2 : 32'd1);
        step();
        chk("idle_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
        chk("idle_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_yheld", 32'(bus.y), 32'(ey));
    endtask

    task automatic run_rand_op();
        int pat;
        pat = $urandom_range(1, 3);
        run_op(pat[0], pat[1], W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    initial begin
        ntests   = 0;
        nfail    = 0;
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a0   = '0;
        bus.b0   = '0;
        bus.a1   = '0;
        bus.b1   = '0;
        model_reset();

        // reset dominates pending requests
        do_reset();
        chk("rst_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
        chk("rst_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ops", 32'(bus.ops), 32'd0);

        run_op(1'b1, 1'b0, 8'hA5, 8'h0F, 8'h00, 8'h00);
        chk("a5_ops", 32'(bus.ops), 32'd1);
        chk("a5_y", 32'(bus.y), 32'hAA);

        for (int i = 0; i < 12; i++) run_rand_op();

        // reset during CALC aborts without ack
        bus.req1 = 1'b1;
        bus.a1   = 8'h3C;
        bus.b1   = 8'h81;
        step();
        chk("abort_gnt1", 32'(bus.gnt1), 32'd1);
        rst      = 1'b1;
        bus.req1 = 1'b0;
        step();
        chk("abort_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
        chk("abort_y", 32'(bus.y), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
        rst = 1'b0;
        model_reset();
        step();
        chk("abort_idle_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
        run_op(1'b0, 1'b1, 8'h00, 8'h00, 8'h3C, 8'h81);

        // both requesters held continuously
        do_reset();
        bus.a0   = 8'h10;
        bus.b0   = 8'h01;
        bus.a1   = 8'h20;
        bus.b1   = 8'h02;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            int  n;
            int  w;
            bit  ackcyc;
            step();
            n = k / 3;
`ifdef XOR_ARB_RR_EN
            w = n % 2;
`else
            w = 0;
`endif
            ackcyc = (k % 3 == 2);
            chk("cont_ack0", 32'(bus.ack0), 32'(ackcyc && w == 0));
            chk("cont_ack1", 32'(bus.ack1), 32'(ackcyc && w == 1));
            chk("cont_gnt0", 32'(bus.gnt0), 32'((k % 3 != 0) && w == 0));
            chk("cont_gnt1", 32'(bus.gnt1), 32'((k % 3 != 0) && w == 1));
            if (ackcyc) chk("cont_y", 32'(bus.y), (w == 0) ? 32'h11 : 32'h22);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        exp_ops = 6;
`ifdef XOR_ARB_RR_EN
        exp_last = 1;
        exp_y    = 8'h22;
`else
        exp_last = 0;
        exp_y    = 8'h11;
`endif
        chk("cont_ops", 32'(bus.ops), 32'(exp_ops));
        chk("cont_idle", 32'(bus.busy), 32'd0);

        // 256 completions wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) run_rand_op();
        chk("wrap_ops", 32'(bus.ops), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
